fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage of the multi-cycle RV32 core. It sits directly downstream of the program counter. On a start pulse from the core control FSM, it takes the current PC and runs a valid/ready request to instruction memory, then waits for the response. It latches the returned word into the instruction register together with the PC it was fetched from (`pc_ir`), which decode/execute and the next-PC logic consume. It also detects memory response timeouts and, optionally, misaligned fetch addresses.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in REQ+WAIT before a timeout fault; 0 disables the timeout.
- `RESET_INSTR`, default 32'h0000_0013: instruction register value after reset (`addi x0,x0,0`).

- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fetch_start`  in  1  one-cycle pulse from the control FSM on entry to FETCH state.
- `pc_in`  in  32  PC register value to fetch from.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  32  request byte address.
- `imem_rsp_valid`  in  1  response data valid.
- `imem_rsp_data`  in  32  instruction word.
- `instr_out`  out  32  instruction register.
- `pc_ir`  out  32  address of the instruction in `instr_out`.
- `fetch_done`  out  1  one-cycle pulse; `instr_out`/`pc_ir` updated this cycle.
- `fetch_fault`  out  1  one-cycle pulse; fetch aborted.
- `fault_cause`  out  1  0 = timeout, 1 = misaligned; valid while `fetch_fault` = 1.
- `busy`  out  1  high in REQ or WAIT.

## Operation
- States are IDLE, REQ, WAIT, plus FAULT when the misalignment check is compiled in.
- **IDLE**
  - `fetch_start` latches `pc_in` into an internal address register, clears the timeout counter and moves to REQ.
  - A `fetch_start` while not in IDLE is ignored.
- **REQ**
  - `imem_req_valid` = 1 and `imem_addr` = latched address, both held stable until `imem_req_ready`.
  - On `valid && ready`, move to WAIT.
- **WAIT**
  - The first cycle with `imem_rsp_valid` = 1 does the following:
    - `instr_out` <= `imem_rsp_data`
    - `pc_ir` <= latched address
    - `fetch_done` pulses
    - move to IDLE.
  - A response can arrive no earlier than the cycle after acceptance. `imem_rsp_valid` in IDLE or REQ is ignored (stale data).
- **Timeout**
  - The counter increments each cycle in REQ or WAIT and saturates.
  - When it equals `TIMEOUT_CYCLES` (nonzero) with no completion that cycle, the block does the following:
    - `fetch_fault` = 1, `fault_cause` = 0
    - drops the request
    - returns to IDLE.
  - `instr_out` and `pc_ir` are unchanged.
  - A response arriving in the same cycle the counter reaches the limit wins: done, no fault.
- **Outputs**
  - `fetch_done` and `fetch_fault` are registered and mutually exclusive.
- **Reset**
  - When `rst_n` is sampled low, the block returns to IDLE from any state, including mid-request.
  - Reset values:
    - `imem_req_valid` = 0, `imem_addr` = 0
    - `instr_out` = `RESET_INSTR`, `pc_ir` = 0
    - `fetch_done` = 0, `fetch_fault` = 0, `fault_cause` = 0, `busy` = 0
    - timeout counter = 0.
  - An in-flight response after reset is discarded.

## Timing
- The `fetch_start` pulse in cycle N puts `imem_req_valid` high in cycle N+1.
- Minimum latency:
  - `imem_req_ready` high in N+1: accept.
  - Response in N+2: `fetch_done`, `instr_out` and `pc_ir` all visible in N+3.
- Each cycle of `imem_req_ready` low adds one cycle of latency. So does each cycle of response latency beyond one.
- Timeout fault is visible the cycle after the counter reaches `TIMEOUT_CYCLES`. That is N+1+`TIMEOUT_CYCLES` at the earliest.
- `busy` is registered and matches the state: high from N+1 through the completion cycle, low when `fetch_done`/`fetch_fault` is seen.
- Counter width is $clog2(`TIMEOUT_CYCLES`+1) bits; it saturates and never wraps.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - At `fetch_start`, if `pc_in[1:0]` != 0, no request is issued.
  - The block enters FAULT. In N+1, `fetch_fault` = 1 and `fault_cause` = 1, then it returns to IDLE.
  - `imem_req_valid` stays 0 throughout.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - `imem_addr` is {`pc_in[31:2]`, 2'b00}, and `pc_ir` records that aligned address.
  - No misaligned fault; `fault_cause` is constant 0.

## Test plan
- Reset then idle: `instr_out` = 32'h0000_0013, `pc_ir` = 0, `imem_req_valid` = 0. Stray `imem_rsp_valid` = 1 with data 32'hDEAD_BEEF must leave `instr_out` unchanged.
- `pc_in` = 32'h0000_0100, `fetch_start` in cycle 0, ready tied high, response 32'h0050_0093 in cycle 2 -> `fetch_done` in cycle 3, `instr_out` = 32'h0050_0093, `pc_ir` = 32'h0000_0100.
- `imem_req_ready` low for 3 cycles -> `imem_addr` stable 32'h0000_0100 throughout; `fetch_done` in cycle 6. A second `fetch_start` during `busy` -> no extra request.
- `TIMEOUT_CYCLES` = 4, no response -> `fetch_fault` = 1, `fault_cause` = 0 in cycle 5, `busy` low. Response exactly at counter = 4 -> `fetch_done`, no fault.
- `rst_n` low in WAIT, response arrives the cycle after reset release -> ignored, no `fetch_done`, IDLE.
- With `FETCH_MISALIGN_CHECK_EN`, `pc_in` = 32'h0000_0102 -> `fetch_fault` = 1, `fault_cause` = 1 in cycle 1, no request. Without the macro -> `imem_addr` = 32'h0000_0100 and a normal fetch.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: latches PC on fetch_start, runs a valid/ready imem request, captures the response.
// Optional misaligned-PC fault when FETCH_MISALIGN_CHECK_EN is defined; otherwise fetches are word-aligned.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for fetch_start
// S_REQ   | imem_req_valid high, address held until imem_req_ready
// S_WAIT  | request accepted, waiting for imem_rsp_valid
// S_FAULT | misaligned PC seen, fault pulse showing (check build only)
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic [31:0] pc_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr_out,
  output logic [31:0] pc_ir,
  output logic        fetch_done,
  output logic        fetch_fault,
  output logic        fault_cause,
  output logic        busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
`endif

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_ir_q, pc_ir_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             req_valid_q, busy_q;
  logic             timeout_hit;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic             cause_q, cause_d;
`endif

  // cnt_inc counts the current cycle, so the limit fires on the T-th cycle spent in REQ+WAIT
  always_comb begin
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = TIMEOUT_EN && (cnt_inc == CNT_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_ir_d = pc_ir_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    cause_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            cause_d = 1'b1;
          end else begin
            addr_d  = pc_in;
            cnt_d   = '0;
            state_d = S_REQ;
          end
`else
          addr_d  = pc_in & ~32'h3;
          cnt_d   = '0;
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // a response on the limit cycle still completes the fetch
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          pc_ir_d = addr_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      instr_q     <= RESET_INSTR;
      pc_ir_q     <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      pc_ir_q     <= pc_ir_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      req_valid_q <= (state_d == S_REQ);
      busy_q      <= (state_d == S_REQ) || (state_d == S_WAIT);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) cause_q <= 1'b0;
    else        cause_q <= cause_d;
  end
  assign fault_cause = cause_q;
`else
  assign fault_cause = 1'b0;
`endif

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = addr_q;
  assign instr_out      = instr_q;
  assign pc_ir          = pc_ir_q;
  assign fetch_done     = done_q;
  assign fetch_fault    = fault_q;
  assign busy           = busy_q;

endmodule
